alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the ALU's operation interface: alu_control, src1, src2. It is the producer end of the ALU operation interface.
- Decodes an RV32I instruction, selects operands (register data, sign-extended immediate, PC or zero), and registers the result into a single ID/EX pipeline slot.
- Upstream and downstream use valid/ready handshakes, so the core can move from single-cycle to a pipelined datapath.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill the slot contents and any input accepted this cycle.
- in_valid  input  1  instruction, PC and operand data are valid.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  RV32I instruction word.
- pc  input  32  instruction address.
- rs1_data  input  32  register-file read port 1.
- rs2_data  input  32  register-file read port 2.
- out_valid  output  1  slot holds an issued operation.
- out_ready  input  1  ALU/EX consumer accepts this cycle.
- alu_control  output  4  add=0000, sub=0001, and=0010, or=0011, xor=0100, sll=0101, srl=0110, sra=0111, slt=1000, sltu=1001.
- src1  output  32  ALU operand 1.
- src2  output  32  ALU operand 2.
- rd  output  5  destination register index.
- reg_write  output  1  result is written back.
- is_branch  output  1  operation is a branch compare.
- illegal  output  1  unsupported or malformed instruction.

Behaviour:
- Single clock. Reset is synchronous and active-high on rst.
- Reset: out_valid=0 and all registered outputs = 0. in_ready follows the handshake rule below.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Load the slot when in_valid && in_ready && !flush. Latency is 1 cycle from acceptance to out_valid.
  - Full throughput with out_ready held high. No combinational path from in_valid to out_valid.
- Slot hold: while out_valid && !out_ready, all outputs hold stable. Input changes are ignored.
- Slot drain: if out_ready is high and no load occurs, out_valid goes to 0 next cycle.
- Flush priority: flush clears out_valid next cycle regardless of other inputs. An input offered in the flush cycle is dropped. rst has priority over flush.
- Immediates:
  - I-type = sign-extended instr[31:20].
  - S-type = sign-extended {instr[31:25], instr[11:7]}.
  - U-type = {instr[31:12], 12'b0}.
- Decode table:
  - OP (0110011): src1=rs1_data, src2=rs2_data, reg_write=1. Operation by funct3:
    - 000: add, or sub if funct7=0100000.
    - 001: sll. 010: slt. 011: sltu. 100: xor.
    - 101: srl, or sra if funct7=0100000.
    - 110: or. 111: and.
    - funct7 must be 0000000, or 0100000 only for funct3 000/101. Anything else is illegal.
  - OP-IMM (0010011): src1=rs1_data, src2=I-imm, reg_write=1. Same funct3 mapping, except 000 is always add.
    - funct3 001 requires instr[31:25]=0000000.
    - funct3 101 requires instr[31:25] = 0000000 (srl) or 0100000 (sra).
    - Otherwise illegal.
  - LUI (0110111): add with src1=0, src2=U-imm, reg_write=1.
  - AUIPC (0010111): add with src1=pc, src2=U-imm, reg_write=1.
  - LOAD (0000011): add with src1=rs1_data, src2=I-imm, reg_write=1.
  - STORE (0100011): add with src1=rs1_data, src2=S-imm, reg_write=0.
  - BRANCH (1100011): src1=rs1_data, src2=rs2_data, reg_write=0, is_branch=1. Operation by funct3:
    - 000/001: sub.
    - 100/101: slt.
    - 110/111: sltu.
    - 010/011: illegal.
  - Any other opcode is illegal.
- Illegal instruction: the slot still loads with out_valid=1, illegal=1, alu_control=add, src1=src2=0, reg_write=0, is_branch=0.
- rd = instr[11:7]. reg_write is forced to 0 when rd=0.

Test Plan:
- Reset, then instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, alu_control=0000, src1=5, src2=7, rd=3, reg_write=1.
- instr=0x402081B3 (sub) -> alu_control=0001. instr=0xFFF00293 (addi x5,x0,-1), rs1_data=0 -> alu_control=0000, src2=0xFFFFFFFF, rd=5.
- instr=0x4043D313 (srai x6,x7,4) -> alu_control=0111, src2[4:0]=4. instr=0x123450B7 (lui x1) -> src1=0, src2=0x12345000, alu_control=0000.
- Back-to-back accepts, then out_ready=0 for 3 cycles -> in_ready=0, outputs frozen. out_ready=1 -> next instruction loads with no bubble and no loss or duplication.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the offered instruction is not issued. rst asserted mid-stall -> out_valid=0 and outputs 0 next cycle.
- instr=0x00000000 or an R-type with funct7=0000001 -> illegal=1, reg_write=0, src1=src2=0. beq (funct3 000) -> alu_control=0001, is_branch=1, reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into ALU control and operands
// and holds the result in a single ID/EX slot with valid/ready handshakes on both sides.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic            illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  // Base funct3 -> ALU op mapping shared by OP and OP-IMM.
  function automatic alu_op_e funct3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  alu_op_e         dec_ctrl;
  logic [XLEN-1:0] dec_src1, dec_src2;
  logic            dec_rw, dec_br, dec_ill;

  always_comb begin
    // NOTE: every decode output gets a default first so no path through the
    // case statement leaves a signal unassigned and infers a latch.
    dec_ctrl = ALU_ADD;
    dec_src1 = rs1_data;
    dec_src2 = imm_i;
    dec_rw   = 1'b1;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_src2 = rs2_data;
        dec_ctrl = funct3_op(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000)      dec_ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec_ctrl = ALU_SRA;
        else if (funct7 != F7_ZERO)                    dec_ill  = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_ctrl = funct3_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_ZERO) dec_ill = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)        dec_ctrl = ALU_SRA;
          else if (funct7 != F7_ZERO)  dec_ill  = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_src1 = '0;
        dec_src2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_src1 = pc;
        dec_src2 = imm_u;
      end
      OPC_LOAD: ;
      OPC_STORE: begin
        dec_src2 = imm_s;
        dec_rw   = 1'b0;
      end
      OPC_BRANCH: begin
        dec_src2 = rs2_data;
        dec_rw   = 1'b0;
        dec_br   = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = ALU_SUB;
          3'b100, 3'b101: dec_ctrl = ALU_SLT;
          3'b110, 3'b111: dec_ctrl = ALU_SLTU;
          default:        dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase

    // Illegal instructions still issue, but as an inert add of zeros.
    if (dec_ill) begin
      dec_ctrl = ALU_ADD;
      dec_src1 = '0;
      dec_src2 = '0;
      dec_rw   = 1'b0;
      dec_br   = 1'b0;
    end
    if (instr[11:7] == 5'd0) dec_rw = 1'b0;
  end

  logic            valid_q;
  logic [3:0]      ctrl_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [4:0]      rd_q;
  logic            rw_q, br_q, ill_q;
  logic            load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (load)      valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;

      if (load) begin
        ctrl_q <= dec_ctrl;
        src1_q <= dec_src1;
        src2_q <= dec_src2;
        rd_q   <= instr[11:7];
        rw_q   <= dec_rw;
        br_q   <= dec_br;
        ill_q  <= dec_ill;
      end
    end
  end

  assign out_valid   = valid_q;
  assign alu_control = ctrl_q;
  assign src1        = src1_q;
  assign src2        = src2_q;
  assign rd          = rd_q;
  assign reg_write   = rw_q;
  assign is_branch   = br_q;
  assign illegal     = ill_q;

endmodule
